// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared types and constants for the load-use hazard detector and its
// ID->EX->MEM->WB control-metadata pipeline.
package hazard_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  // Stall down-counter width; STALL_CYCLES is limited to 1..3.
  localparam int CNT_W = 2;

  typedef enum logic {IDLE, STALL} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wren;
  } stage_meta_t;

  function automatic stage_meta_t nop_meta(input logic [31:0] nop);
    stage_meta_t m;
    m      = '0;
    m.inst = nop;
    return m;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    logic u;
    case (opc)
      LUI, AUIPC, JAL:                          u = 1'b0;
      LOAD, STORE, OP, OP_IMM, BRANCH, JALR:    u = 1'b1;
      default:                                  u = 1'b1;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP) || (opc == STORE) || (opc == BRANCH);
  endfunction

endpackage

// File: rtl/hazard_pipe_ctrl_stage_reg.sv
// One pipeline stage of control metadata; a flush or reset loads a NOP
// bubble (NOP_INST, wren=0, all addresses 0).
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  stage_meta_t i_meta,
  output stage_meta_t o_meta
);

  stage_meta_t meta_q;
  stage_meta_t meta_d;

  always_comb begin
    meta_d = i_meta;
    if (i_flush) meta_d = nop_meta(NOP_INST);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) meta_q <= nop_meta(NOP_INST);
    else          meta_q <= meta_d;
  end

  assign o_meta = meta_q;

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Load-use hazard detection, stall/flush control and EX/MEM/WB metadata pipe.
// Optional HAZARD_PERF_CNT_EN adds saturating bubble/redirect counters.
module hazard_pipe_ctrl
  import hazard_pkg::*;
#(
  parameter int          STALL_CYCLES = 1,
  parameter logic [31:0] NOP_INST     = NOP_INST_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_ID_inst,
  input  logic        i_ID_rd_wren,
  input  logic        i_EX_redirect,
  output logic        o_pc_stall,
  output logic        o_IF_ID_stall,
  output logic        o_IF_ID_flush,
  output logic        o_ID_EX_flush,
  output logic [31:0] o_EX_inst,
  output logic [4:0]  o_EX_rs1_addr,
  output logic [4:0]  o_EX_rs2_addr,
  output logic [31:0] o_MEM_inst,
  output logic [4:0]  o_MEM_rs2_addr,
  output logic        o_MEM_rd_wren,
  output logic [4:0]  o_MEM_rd_addr,
  output logic [31:0] o_WB_inst,
  output logic        o_WB_rd_wren,
  output logic [4:0]  o_WB_rd_addr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              hazard;
  logic [6:0]        id_opc;
  logic              match_rs1;
  logic              match_rs2;
  logic              ex_is_load;
  stage_meta_t       id_meta, ex_q, mem_q, wb_q;
  logic              unused_wb;

  assign id_opc       = i_ID_inst[6:0];
  assign id_meta.inst = i_ID_inst;
  assign id_meta.rs1  = i_ID_inst[19:15];
  assign id_meta.rs2  = i_ID_inst[24:20];
  assign id_meta.rd   = i_ID_inst[11:7];
  assign id_meta.wren = i_ID_rd_wren;

  // A store whose only dependency is its data operand is not stalled:
  // that value is forwarded into MEM from WB further down the pipe.
  assign ex_is_load = (ex_q.inst[6:0] == LOAD) && (ex_q.rd != 5'd0) && ex_q.wren;
  assign match_rs1  = uses_rs1(id_opc) && (id_meta.rs1 == ex_q.rd);
  assign match_rs2  = uses_rs2(id_opc) && (id_meta.rs2 == ex_q.rd);
  assign hazard     = ex_is_load && (match_rs1 || (match_rs2 && (id_opc != STORE)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (i_EX_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard) begin
            stall       = 1'b1;
            id_ex_flush = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = CNT_W'(STALL_CYCLES - 1);
            end
          end
        end
        STALL: begin
          stall       = 1'b1;
          id_ex_flush = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  hazard_stage_reg #(.NOP_INST(NOP_INST)) u_ex (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(id_ex_flush), .i_meta(id_meta), .o_meta(ex_q)
  );
  hazard_stage_reg #(.NOP_INST(NOP_INST)) u_mem (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(1'b0), .i_meta(ex_q), .o_meta(mem_q)
  );
  hazard_stage_reg #(.NOP_INST(NOP_INST)) u_wb (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(1'b0), .i_meta(mem_q), .o_meta(wb_q)
  );

  assign unused_wb = ^{wb_q.rs1, wb_q.rs2};

  assign o_pc_stall     = stall;
  assign o_IF_ID_stall  = stall;
  assign o_IF_ID_flush  = if_id_flush;
  assign o_ID_EX_flush  = id_ex_flush;
  assign o_EX_inst      = ex_q.inst;
  assign o_EX_rs1_addr  = ex_q.rs1;
  assign o_EX_rs2_addr  = ex_q.rs2;
  assign o_MEM_inst     = mem_q.inst;
  assign o_MEM_rs2_addr = mem_q.rs2;
  assign o_MEM_rd_wren  = mem_q.wren;
  assign o_MEM_rd_addr  = mem_q.rd;
  assign o_WB_inst      = wb_q.inst;
  assign o_WB_rd_wren   = wb_q.wren;
  assign o_WB_rd_addr   = wb_q.rd;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)         stall_cnt_q <= sat_inc(stall_cnt_q);
      if (i_EX_redirect) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Scoreboard bench for hazard_pipe_ctrl: one instance with STALL_CYCLES=1 and
// one with STALL_CYCLES=3 share stimulus; sel picks which one is checked.
module tb_hazard_pipe_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wren;
  } exp_t;

  typedef struct packed {
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic [31:0] ex_inst;
    logic [4:0]  ex_rs1, ex_rs2;
    logic [31:0] mem_inst;
    logic [4:0]  mem_rs2;
    logic        mem_wren;
    logic [4:0]  mem_rd;
    logic [31:0] wb_inst;
    logic        wb_wren;
    logic [4:0]  wb_rd;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = NOP;
  logic        id_wren = 1'b0;
  logic        redirect = 1'b0;
  logic        sel = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t exq[$];
  exp_t memq[$];
  exp_t wbq[$];

  always #5 clk = ~clk;

  logic        a_pcs, a_ifs, a_iff, a_ief, a_mw, a_ww;
  logic [31:0] a_exi, a_mi, a_wi;
  logic [4:0]  a_er1, a_er2, a_mr2, a_mrd, a_wrd;
  logic        b_pcs, b_ifs, b_iff, b_ief, b_mw, b_ww;
  logic [31:0] b_exi, b_mi, b_wi;
  logic [4:0]  b_er1, b_er2, b_mr2, b_mrd, b_wrd;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

  hazard_pipe_ctrl #(.STALL_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_ID_inst(id_inst), .i_ID_rd_wren(id_wren),
    .i_EX_redirect(redirect), .o_pc_stall(a_pcs), .o_IF_ID_stall(a_ifs),
    .o_IF_ID_flush(a_iff), .o_ID_EX_flush(a_ief), .o_EX_inst(a_exi),
    .o_EX_rs1_addr(a_er1), .o_EX_rs2_addr(a_er2), .o_MEM_inst(a_mi),
    .o_MEM_rs2_addr(a_mr2), .o_MEM_rd_wren(a_mw), .o_MEM_rd_addr(a_mrd),
    .o_WB_inst(a_wi), .o_WB_rd_wren(a_ww), .o_WB_rd_addr(a_wrd)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt)
`endif
  );

  hazard_pipe_ctrl #(.STALL_CYCLES(3)) dut3 (
    .i_clk(clk), .i_reset(rst_n), .i_ID_inst(id_inst), .i_ID_rd_wren(id_wren),
    .i_EX_redirect(redirect), .o_pc_stall(b_pcs), .o_IF_ID_stall(b_ifs),
    .o_IF_ID_flush(b_iff), .o_ID_EX_flush(b_ief), .o_EX_inst(b_exi),
    .o_EX_rs1_addr(b_er1), .o_EX_rs2_addr(b_er2), .o_MEM_inst(b_mi),
    .o_MEM_rs2_addr(b_mr2), .o_MEM_rd_wren(b_mw), .o_MEM_rd_addr(b_mrd),
    .o_WB_inst(b_wi), .o_WB_rd_wren(b_ww), .o_WB_rd_addr(b_wrd)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
`endif
  );

  obs_t obs;
  always_comb begin
    if (sel)
      obs = '{b_pcs, b_ifs, b_iff, b_ief, b_exi, b_er1, b_er2, b_mi, b_mr2, b_mw, b_mrd, b_wi, b_ww, b_wrd};
    else
      obs = '{a_pcs, a_ifs, a_iff, a_ief, a_exi, a_er1, a_er2, a_mi, a_mr2, a_mw, a_mrd, a_wi, a_ww, a_wrd};
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'd2, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] off);
    return {7'd0, rs2, rs1, 3'd2, off, 7'b0100011};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] imm);
    return {7'd0, imm, rs1, 3'd0, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] hi);
    return {hi, rd, 7'b0110111};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e      = '0;
    e.inst = NOP;
    return e;
  endfunction

  task automatic sb_compare();
    exp_t e;
    if (wbq.size() == 0 || memq.size() == 0 || exq.size() == 0) begin
      check("sb_queue_underrun", 32'd0, 32'd1);
      return;
    end
    e = wbq.pop_front();
    check("wb_inst", obs.wb_inst, e.inst);
    check("wb_wren", {31'd0, obs.wb_wren}, {31'd0, e.wren});
    check("wb_rd", {27'd0, obs.wb_rd}, {27'd0, e.rd});
    e = memq.pop_front();
    check("mem_inst", obs.mem_inst, e.inst);
    check("mem_rs2", {27'd0, obs.mem_rs2}, {27'd0, e.rs2});
    check("mem_wren", {31'd0, obs.mem_wren}, {31'd0, e.wren});
    check("mem_rd", {27'd0, obs.mem_rd}, {27'd0, e.rd});
    wbq.push_back(e);
    e = exq.pop_front();
    check("ex_inst", obs.ex_inst, e.inst);
    check("ex_rs1", {27'd0, obs.ex_rs1}, {27'd0, e.rs1});
    check("ex_rs2", {27'd0, obs.ex_rs2}, {27'd0, e.rs2});
    memq.push_back(e);
  endtask

  // One clock: drive ID, check stall/flush, queue what EX must hold next.
  task automatic step(input logic [31:0] inst, input logic wren, input logic redir,
                      input logic e_stall, input logic e_fif, input logic e_fie);
    exp_t e;
    @(negedge clk);
    id_inst  = inst;
    id_wren  = wren;
    redirect = redir;
    #1;
    check("pc_stall", {31'd0, obs.pc_stall}, {31'd0, e_stall});
    check("if_id_stall", {31'd0, obs.ifid_stall}, {31'd0, e_stall});
    check("if_id_flush", {31'd0, obs.ifid_flush}, {31'd0, e_fif});
    check("id_ex_flush", {31'd0, obs.idex_flush}, {31'd0, e_fie});
    if (e_fie) e = bubble();
    else       e = '{inst, inst[19:15], inst[24:20], inst[11:7], wren};
    exq.push_back(e);
    @(posedge clk);
    #1;
    sb_compare();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut(input bit at_negedge);
    if (at_negedge) @(negedge clk);
    rst_n    = 1'b0;
    id_inst  = NOP;
    id_wren  = 1'b0;
    redirect = 1'b0;
    #1;
    check("rst_pc_stall", {31'd0, obs.pc_stall}, 32'd0);
    check("rst_if_id_flush", {31'd0, obs.ifid_flush}, 32'd0);
    check("rst_id_ex_flush", {31'd0, obs.idex_flush}, 32'd0);
    check("rst_ex_inst", obs.ex_inst, NOP);
    check("rst_mem_inst", obs.mem_inst, NOP);
    check("rst_wb_inst", obs.wb_inst, NOP);
    check("rst_mem_wren", {31'd0, obs.mem_wren}, 32'd0);
    check("rst_wb_rd", {27'd0, obs.wb_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exq.delete();
    memq.delete();
    wbq.delete();
    memq.push_back(bubble());
    wbq.push_back(bubble());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    reset_dut(1'b1);

    // Load-use with a single bubble
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(add(6, 5, 2), 1, 0, 1, 0, 1);
    step(add(6, 5, 2), 1, 0, 0, 0, 0);
    drain(2);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cnt", a_scnt, 32'd1);
`endif

    // Hazard coincident with redirect: flush wins, no stall
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(add(6, 5, 2), 1, 1, 0, 1, 1);
    drain(2);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cnt2", a_scnt, 32'd1);
    check("perf_flush_cnt", a_fcnt, 32'd1);
`endif

    // Store data dependency only: no stall; store base dependency: stall
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(sw(5, 3, 4), 0, 0, 0, 0, 0);
    drain(3);
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(sw(7, 5, 0), 0, 0, 1, 0, 1);
    step(sw(7, 5, 0), 0, 0, 0, 0, 0);
    drain(2);

    // x0 destination, non-writing load, and unused source fields
    step(ld(0, 1), 1, 0, 0, 0, 0);
    step(add(6, 0, 2), 1, 0, 0, 0, 0);
    step(ld(5, 1), 0, 0, 0, 0, 0);
    step(add(6, 5, 5), 1, 0, 0, 0, 0);
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(lui(7, 20'h0_0028), 1, 0, 0, 0, 0);
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(addi(6, 1, 5), 1, 0, 0, 0, 0);
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(add(6, 2, 5), 1, 0, 1, 0, 1);
    step(add(6, 2, 5), 1, 0, 0, 0, 0);
    drain(2);

    // Three-bubble instance
    sel = 1'b1;
    reset_dut(1'b1);
    step(ld(5, 1), 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(add(6, 5, 2), 1, 0, 1, 0, 1);
    step(add(6, 5, 2), 1, 0, 0, 0, 0);
    drain(3);

    // Redirect during STALL returns to IDLE next cycle
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(add(6, 5, 2), 1, 0, 1, 0, 1);
    step(add(6, 5, 2), 1, 1, 0, 1, 1);
    step(NOP, 0, 0, 0, 0, 0);
    drain(2);

    // Asynchronous reset in the middle of STALL
    step(ld(5, 1), 1, 0, 0, 0, 0);
    step(add(6, 5, 2), 1, 0, 1, 0, 1);
    reset_dut(1'b0);
    step(add(6, 5, 2), 1, 0, 0, 0, 0);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
